// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and registered in_ready.
// Optional STAGE_PERF_EN macro adds saturating stall/bubble counters.
module pipe_stage_skid_reg #(
    parameter int unsigned       CTRL_W   = 8,
    parameter int unsigned       DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e             state_q;
    logic               in_ready_q;
    logic [CTRL_W-1:0]  main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0]  main_data_q, skid_data_q;
    logic               accept, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // Bubbles present CTRL_RST so a stale main register never leaks control bits.
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_RST;
    assign out_data  = main_data_q;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // in_ready_q always tracks (next state != StTwo).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q     <= StOne;
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (accept) begin
                        state_q     <= StTwo;
                        in_ready_q  <= 1'b0;
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_q     <= StOne;
                        in_ready_q  <= 1'b1;
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef STAGE_PERF_EN
    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!out_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed vector table, async reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_skid_reg;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_ctrl = '0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
`ifdef STAGE_PERF_EN
    logic [31:0]  stall_cnt, bubble_cnt;
`endif

    pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(128), .CTRL_RST(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passes++;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic eir,
                              input logic [1:0] eocc, input logic [7:0] eoc,
                              input logic [127:0] eod);
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(ev));
        chk({tag, ".in_ready"},  128'(in_ready),  128'(eir));
        chk({tag, ".occupancy"}, 128'(occupancy), 128'(eocc));
        chk({tag, ".out_ctrl"},  128'(out_ctrl),  128'(eoc));
        chk({tag, ".out_data"},  out_data,        eod);
    endtask

    typedef struct {
        logic         fl, iv, ordy;
        logic [7:0]   ctrl;
        logic [127:0] data;
        logic         e_ov, e_ir;
        logic [1:0]   e_occ;
        logic [7:0]   e_oc;
        logic [127:0] e_od;
    } vec_t;

    vec_t vecs[15];

    // Reference model: a FIFO of at most two beats.
    logic [7:0]   mq_c[$];
    logic [127:0] mq_d[$];
    logic         m_ir;
    logic [127:0] m_last;

    task automatic model_step(input logic fl, input logic iv, input logic ordy,
                              input logic [7:0] c, input logic [127:0] d);
        logic acc, pp;
        acc = iv && m_ir;
        pp  = (mq_d.size() > 0) && ordy;
        if (fl) begin
            mq_c.delete();
            mq_d.delete();
        end else begin
            if (pp) begin
                void'(mq_c.pop_front());
                void'(mq_d.pop_front());
            end
            if (acc) begin
                mq_c.push_back(c);
                mq_d.push_back(d);
            end
        end
        m_ir = (mq_d.size() < 2);
        if (mq_d.size() > 0) m_last = mq_d[0];
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy,
                         input logic [7:0] c, input logic [127:0] d);
        flush = fl; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{0, 1, 1, 8'h81, 128'h1,    1, 1, 2'd1, 8'h81, 128'h1};
        vecs[1]  = '{0, 1, 1, 8'h81, 128'h2,    1, 1, 2'd1, 8'h81, 128'h2};
        vecs[2]  = '{0, 1, 1, 8'h81, 128'h3,    1, 1, 2'd1, 8'h81, 128'h3};
        vecs[3]  = '{0, 1, 1, 8'h81, 128'h4,    1, 1, 2'd1, 8'h81, 128'h4};
        vecs[4]  = '{0, 1, 1, 8'h81, 128'hA,    1, 1, 2'd1, 8'h81, 128'hA};
        vecs[5]  = '{0, 1, 0, 8'h82, 128'hB,    1, 0, 2'd2, 8'h81, 128'hA};
        vecs[6]  = '{0, 1, 1, 8'h99, 128'hEE,   1, 1, 2'd1, 8'h82, 128'hB};
        vecs[7]  = '{0, 0, 1, 8'h00, 128'h0,    0, 1, 2'd0, 8'h00, 128'hB};
        vecs[8]  = '{0, 1, 0, 8'h83, 128'hC,    1, 1, 2'd1, 8'h83, 128'hC};
        vecs[9]  = '{0, 1, 1, 8'h84, 128'hD,    1, 1, 2'd1, 8'h84, 128'hD};
        vecs[10] = '{0, 1, 0, 8'h85, 128'hE,    1, 0, 2'd2, 8'h84, 128'hD};
        vecs[11] = '{1, 1, 0, 8'h86, 128'hF,    0, 1, 2'd0, 8'h00, 128'hD};
        vecs[12] = '{0, 1, 0, 8'h87, 128'h10,   1, 1, 2'd1, 8'h87, 128'h10};
        vecs[13] = '{1, 1, 0, 8'h88, 128'h11,   0, 1, 2'd0, 8'h00, 128'h10};
        vecs[14] = '{0, 0, 1, 8'h00, 128'h0,    0, 1, 2'd0, 8'h00, 128'h10};

        #1 rst = 1'b1;
        #1 check_outs("reset", 1'b0, 1'b1, 2'd0, 8'h00, 128'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].ctrl, vecs[i].data);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ,
                       vecs[i].e_oc, vecs[i].e_od);
        end

        // Async reset while holding two beats, asserted between edges.
        drive(0, 1, 0, 8'h90, 128'h20);
        step();
        drive(0, 1, 0, 8'h91, 128'h21);
        step();
        chk("pre_rst.occupancy", 128'(occupancy), 128'd2);
        drive(0, 0, 0, 8'h00, 128'h0);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 1'b0, 1'b1, 2'd0, 8'h00, 128'h0);
        #1 rst = 1'b0;
        drive(0, 1, 1, 8'h5A, 128'h55);
        step();
        check_outs("post_rst", 1'b1, 1'b1, 2'd1, 8'h5A, 128'h55);
        drive(0, 0, 0, 8'h00, 128'h0);

        // Randomized traffic against the queue model.
        rst = 1'b1;
        #1 rst = 1'b0;
        mq_c.delete();
        mq_d.delete();
        m_ir = 1'b1;
        m_last = '0;
        for (int n = 0; n < 500; n++) begin
            logic fl, iv, ordy;
            logic [7:0] c;
            logic [127:0] d;
            fl   = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            c    = 8'($urandom);
            d    = {$urandom, $urandom, $urandom, $urandom};
            drive(fl, iv, ordy, c, d);
            model_step(fl, iv, ordy, c, d);
            step();
            check_outs($sformatf("rand%0d", n), mq_d.size() > 0, m_ir, 2'(mq_d.size()),
                       (mq_c.size() > 0) ? mq_c[0] : 8'h00, m_last);
        end

`ifdef STAGE_PERF_EN
        begin
            logic [31:0] s0, b0;
            drive(1, 0, 0, 8'h00, 128'h0);
            step();
            s0 = stall_cnt;
            b0 = bubble_cnt;
            drive(0, 1, 0, 8'hC1, 128'h77);
            step();
            drive(0, 0, 0, 8'h00, 128'h0);
            repeat (3) step();
            drive(0, 0, 1, 8'h00, 128'h0);
            step();
            repeat (2) step();
            chk("perf.stall", 128'(stall_cnt - s0), 128'd3);
            chk("perf.bubble", 128'(bubble_cnt - b0), 128'd3);
            drive(1, 0, 1, 8'h00, 128'h0);
            step();
            drive(0, 0, 0, 8'h00, 128'h0);
            chk("perf.flush_stall", 128'(stall_cnt - s0), 128'd3);
            chk("perf.flush_bubble", 128'(bubble_cnt - b0), 128'd4);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Generic, parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
- Successor to the fixed-field stage registers between ID/EXE/MEM/WB; payload split into control field (zeroed on bubble/flush, so a bubble is a NOP) and data field.
- Registered in_ready breaks the backpressure combinational path, so hazard stalls no longer ripple back through the pipeline in one cycle.

Parameters:
- CTRL_W, 8, control bits (WB_EN, MEM_R_EN, MEM_W_EN, B, S, ...); forced to 0 whenever out_valid=0.
- DATA_W, 128, data bits (PC, operand values, immediates, dest/src ids); held, not cleared, on bubble.
- CTRL_RST, 0 (CTRL_W bits), value driven on out_ctrl when the stage is empty.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous flush (branch taken); kills all held entries.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  stage can accept; registered.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream data field.
- out_valid  output  1  stage holds a valid beat.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  head control field; CTRL_RST when out_valid=0.
- out_data  output  DATA_W  head data field.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the same rising edge.
- Storage: main reg (drives outputs) + skid reg. States:
  - EMPTY: occupancy=0.
  - ONE: main full.
  - TWO: main and skid full.
- in_ready = (state != TWO), registered from the next-state value.
- EMPTY: accept -> ONE, main <= in.
- ONE:
  - accept & pop -> ONE, main <= in.
  - accept & !pop -> TWO, skid <= in.
  - pop & !accept -> EMPTY.
  - neither -> hold.
- TWO (in_ready=0, so no accept): pop -> ONE, main <= skid; else hold.
- Latency: 1 cycle in->out when downstream ready; full throughput of 1 beat/cycle with out_ready held high.
- Ordering strictly FIFO; no beat dropped or duplicated except by flush/rst.
- Flush, priority below rst and above all else:
  - Next state EMPTY; out_valid=0; out_ctrl=CTRL_RST; in_ready=1 next cycle.
  - A beat accepted in the flush cycle is discarded.
  - out_data is not cleared.
- Reset: state EMPTY; out_valid=0; in_ready=1; out_ctrl=CTRL_RST; out_data=0; skid=0; occupancy=0.
  - Reset mid-operation discards all entries immediately (asynchronous).
- out_ctrl is CTRL_RST (muxed combinationally from state) whenever out_valid=0, regardless of stale main contents.
- out_valid and out_data must stay stable while out_valid & !out_ready.

Optional Feature:
- Macro STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at 32'hFFFF_FFFF and reset to 0 on rst; flush does not clear them.
- Not defined: ports and counter logic absent; behaviour otherwise identical.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 4 cycles, data 0x1..0x4, ctrl 8'h81 -> out beats 0x1..0x4 on cycles 1..4, occupancy stays 1, in_ready stays 1.
- Backpressure into skid:
  - ONE holding 0xA, out_ready=0, accept 0xB -> occupancy=2, in_ready=0 next cycle.
  - Raise out_ready -> 0xA then 0xB delivered in order; in_ready=1 after 0xA pops.
- Simultaneous: ONE holding 0xC, accept 0xD with pop same edge -> next cycle out_data=0xD, occupancy=1, no skid use.
- Flush with 2 entries plus in_valid=1 same cycle -> next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0, in_ready=1; the flushed input beat never appears.
- Async reset asserted mid-cycle while TWO -> outputs reach reset values before the next clk edge; after release, first accepted beat 0x55 appears with out_valid=1 one cycle later.
- STAGE_PERF_EN: 3 cycles out_valid=1 & out_ready=0, then 2 empty cycles -> stall_cnt=3, bubble_cnt includes 2; a flush leaves both unchanged.
